// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier scheduler.
//   MUL_LAT   - latency of the shared wallace_mult8 instance
//   RSP_DEPTH - default response-buffer depth (also the credit limit)
//   ID_W      - requester-id width sized for the largest legal NREQ (8)
//   tag_t     - {valid, id} carried alongside the multiplier pipeline
package mult_arb_pkg;

    localparam int MUL_LAT   = 3;
    localparam int RSP_DEPTH = 2;
    localparam int MAX_NREQ  = 8;

    // $clog2(n) but never below 1, so a 2-requester build still gets an id bit.
    function automatic int calc_id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = calc_id_w(MAX_NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_arb_rsp_fifo.sv
// mult_arb_rsp_fifo: DEPTH-entry, 16-bit synchronous FIFO holding products
// for one requester.
//   clk, rst_n       - clock, synchronous active-low reset
//   push, push_data  - write one product
//   pop              - consume the head (ignored when empty)
//   valid, head      - head present / head data (0 when empty)
//   count            - number of stored entries
// A push into a full buffer is accepted only when a pop frees the slot in the
// same cycle; upstream credits keep any other full-push from happening.
module mult_arb_rsp_fifo
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [15:0]      push_data,
    input  logic             pop,
    output logic             valid,
    output logic [15:0]      head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][15:0] mem;
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic                   do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid   = (count != '0);
    assign head    = valid ? mem[rd_ptr] : '0;
    assign do_pop  = pop & valid;
    // When full, wr_ptr == rd_ptr: overwriting the slot being popped is safe
    // because the head is read combinationally before the edge.
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mult_arb_sched.sv
// mult_arb_sched: round-robin scheduler sharing one pipelined 8x8 multiplier
// among NREQ requesters, with credit-limited per-requester response buffers.
//   clk, rst_n                  - clock, synchronous active-low reset (also
//                                 resets the external multiplier)
//   req_valid/req_a/req_b       - operand pairs, 8 bits per requester
//   req_ready                   - combinational one-hot grant
//   mul_in_valid/mul_a/mul_b    - to multiplier
//   mul_out_valid/mul_product   - from multiplier, LAT cycles later
//   rsp_valid/rsp_product/rsp_ready - per-requester response buffer heads
//   tag_err                     - sticky: tag pipeline disagreed with multiplier
//   perf_grants                 - saturating grant counts, only when
//                                 MULT_ARB_PERF_EN is defined
module mult_arb_sched
    import mult_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = MUL_LAT,
    parameter int DEPTH = RSP_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*8-1:0]  req_a,
    input  logic [NREQ*8-1:0]  req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               mul_in_valid,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    input  logic               mul_out_valid,
    input  logic [15:0]        mul_product,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*16-1:0] rsp_product,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic               tag_err
`ifdef MULT_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0] perf_grants
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0][CW-1:0] credit, fifo_cnt;
    logic [NREQ-1:0][15:0]   fifo_head;
    logic [NREQ-1:0]         eligible, grant, pop, push, fifo_valid;
    logic [ID_W-1:0]         rr_ptr, gid;
    logic                    found;
    int                      idx;
    tag_t                    tag_in;
    tag_t [LAT:1]            vld_pipe;

    // Round-robin search starting at rr_ptr; first eligible requester wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = ID_W'(idx);
            end
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[8*i +: 8];
                mul_b = req_b[8*i +: 8];
            end
        end
    end

    assign req_ready    = grant & {NREQ{rst_n}};
    assign mul_in_valid = (|grant) & rst_n;
    assign tag_in       = '{valid: |grant, id: gid};

    // Tag pipeline: no stall, stage LAT lines up with mul_out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_err  <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            vld_pipe[1] <= tag_in;
            for (int k = 2; k <= LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            if (mul_out_valid != vld_pipe[LAT].valid)
                tag_err <= 1'b1;
            if (|grant)
                rr_ptr <= ID_W'((int'(gid) + 1) % NREQ);
        end
    end

    // Credits count buffer slots not yet claimed by in-flight or stored results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++)
                credit[i] <= CW'(DEPTH);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !pop[i])
                    credit[i] <= credit[i] - CW'(1);
                else if (pop[i] && !grant[i])
                    credit[i] <= credit[i] + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign eligible[i] = req_valid[i] & (credit[i] != '0);
        assign pop[i]      = rsp_ready[i] & (fifo_cnt[i] != '0);
        // A mismatched tag never pushes: the product is dropped.
        assign push[i]     = mul_out_valid & vld_pipe[LAT].valid &
                             (vld_pipe[LAT].id == ID_W'(i));

        mult_arb_rsp_fifo #(.DEPTH(DEPTH), .CNT_W(CW)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (mul_product),
            .pop       (pop[i]),
            .valid     (fifo_valid[i]),
            .head      (fifo_head[i]),
            .count     (fifo_cnt[i])
        );

        assign rsp_valid[i]            = fifo_valid[i] & rst_n;
        assign rsp_product[16*i +: 16] = rst_n ? fifo_head[i] : 16'h0;
    end

`ifdef MULT_ARB_PERF_EN
    logic [NREQ-1:0][15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (grant[i] && perf_cnt[i] != 16'hFFFF)
                    perf_cnt[i] <= perf_cnt[i] + 16'd1;
        end
    end

    assign perf_grants = perf_cnt;
`endif

endmodule

// File: tb/tb_mult_arb_sched.sv
// tb_mult_arb_sched: directed + randomized bench for mult_arb_sched with a
// behavioural 3-cycle multiplier and a queue-based reference model.
module tb_mult_arb_sched;

    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*8-1:0]  req_a, req_b;
    logic               mul_in_valid, mul_out_valid, tag_err;
    logic [7:0]         mul_a, mul_b;
    logic [15:0]        mul_product;
    logic [NREQ*16-1:0] rsp_product;
`ifdef MULT_ARB_PERF_EN
    logic [NREQ*16-1:0] perf_grants;
`endif

    mult_arb_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .mul_in_valid  (mul_in_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_out_valid (mul_out_valid),
        .mul_product   (mul_product),
        .rsp_valid     (rsp_valid),
        .rsp_product   (rsp_product),
        .rsp_ready     (rsp_ready),
        .tag_err       (tag_err)
`ifdef MULT_ARB_PERF_EN
        ,
        .perf_grants   (perf_grants)
`endif
    );

    // Behavioural stand-in for the shared pipelined multiplier.
    logic [LAT:1] mv;
    logic [15:0]  mp [LAT:1];
    logic         inj;

    always @(posedge clk) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            mv[1] <= mul_in_valid;
            mp[1] <= 16'(mul_a) * 16'(mul_b);
            for (int k = 2; k <= LAT; k++) begin
                mv[k] <= mv[k-1];
                mp[k] <= mp[k-1];
            end
        end
    end

    assign mul_out_valid = mv[LAT] | inj;
    assign mul_product   = mp[LAT];

    // Reference model: per-requester queue of {visible_cycle, product}.
    // Outstanding work = queue size, so credit = DEPTH - size.
    longint unsigned q [NREQ][$];
    bit              iss [int];
    int              rr_m;
    bit              terr_m;
    int              now;
    int              tests, fails;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    // One clock: check outputs at the negedge, advance the model, end at posedge+1.
    task automatic step();
        int                 g;
        int                 id;
        logic [NREQ-1:0]    eg, ev;
        logic [NREQ*16-1:0] ep;
        logic [7:0]         ea, eb;
        longint unsigned    h;
        @(negedge clk);
        g  = -1;
        eg = '0;
        ev = '0;
        ep = '0;
        ea = '0;
        eb = '0;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, '0);
            chk("rst_mul_in_valid", mul_in_valid, 1'b0);
            chk("rst_rsp_valid", rsp_valid, '0);
            chk("rst_rsp_product", rsp_product, '0);
            for (int i = 0; i < NREQ; i++) q[i].delete();
            iss.delete();
            rr_m   = 0;
            terr_m = 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                id = (rr_m + k) % NREQ;
                if (g < 0 && req_valid[id] && q[id].size() < DEPTH) g = id;
            end
            if (g >= 0) begin
                eg[g] = 1'b1;
                ea    = req_a[8*g +: 8];
                eb    = req_b[8*g +: 8];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() > 0) begin
                    h = q[i][0];
                    if (int'(h >> 16) <= now) begin
                        ev[i]         = 1'b1;
                        ep[16*i +: 16] = h[15:0];
                    end
                end
            end
            chk("req_ready", req_ready, eg);
            chk("mul_in_valid", mul_in_valid, |eg);
            chk("mul_a", mul_a, ea);
            chk("mul_b", mul_b, eb);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_product", rsp_product, ep);
            chk("tag_err", tag_err, terr_m);
            // advance model to the coming edge
            if (mul_out_valid && !iss.exists(now - LAT)) terr_m = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (ev[i] && rsp_ready[i]) void'(q[i].pop_front());
            if (g >= 0) begin
                q[g].push_back((longint'(now + LAT + 1) << 16) |
                               longint'(16'(ea) * 16'(eb)));
                iss[now] = 1'b1;
                rr_m     = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    initial begin
        tests = 0; fails = 0; now = 0; rr_m = 0; terr_m = 1'b0;
        rst_n = 1'b0; inj = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        step(); step();
        rst_n = 1'b1;

        // Reset state with idle inputs
        repeat (2) step();

        // Single issue: 200*100 visible four cycles later
        req_valid = 4'b0001; req_a[7:0] = 8'd200; req_b[7:0] = 8'd100;
        step();
        req_valid = '0;
        repeat (3) step();
        chk("single_rsp_valid", rsp_valid[0], 1'b1);
        chk("single_product", rsp_product[15:0], 16'd20000);
        rsp_ready = 4'hF;
        step();
        rsp_ready = '0;

        // Round robin, all requesters, all popping
        req_valid = 4'hF; rsp_ready = 4'hF;
        repeat (8) begin
            req_a = 32'($urandom); req_b = 32'($urandom);
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Credit limit on requester 2
        rsp_ready = '0; req_valid = 4'b0100;
        req_a[23:16] = 8'd255; req_b[23:16] = 8'd255; step();
        req_a[23:16] = 8'd1;   req_b[23:16] = 8'd1;   step();
        req_a[23:16] = 8'd7;   req_b[23:16] = 8'd9;
        repeat (6) step();
        chk("credit_block", req_ready[2], 1'b0);
        chk("credit_head", rsp_product[47:32], 16'd65025);
        rsp_ready[2] = 1'b1;
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Full buffer then continuous pop with a streaming requester 0
        rsp_ready = '0; req_valid = 4'b0001;
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd5;
        repeat (6) step();
        rsp_ready[0] = 1'b1;
        repeat (10) begin
            req_a[7:0] = 8'($urandom); req_b[7:0] = 8'($urandom);
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Randomized traffic
        repeat (300) begin
            req_valid = 4'($urandom); rsp_ready = 4'($urandom);
            req_a = 32'($urandom);    req_b = 32'($urandom);
            step();
        end
        req_valid = '0; rsp_ready = 4'hF;
        repeat (8) step();

        // Reset with three operations in flight
        rsp_ready = '0; req_valid = 4'hF;
        repeat (3) step();
        rst_n = 1'b0; req_valid = '0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("midreset_rsp_valid", rsp_valid, '0);
        req_valid = 4'hF;
        step();
        req_valid = '0;
        repeat (6) step();
        rsp_ready = 4'hF;
        step();
        rsp_ready = '0;

        // Spurious multiplier output with an empty tag stage
        repeat (4) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (4) step();
        chk("tag_err_sticky", tag_err, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("tag_err_cleared", tag_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
